// File: rtl/arbiter_pkg.sv
// Shared definitions for the weighted round-robin burst arbiter: state
// encoding and the burst-weight normalisation rule.
package arbiter_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    GRANT = ST_GRANT
  } state_e;

  localparam int WMAX = 16;

  // A programmed weight of zero still grants one beat so a requester is never starved.
  function automatic logic [WMAX-1:0] eff_weight(input logic [WMAX-1:0] w);
    return (w == '0) ? WMAX'(1) : w;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first asserted request scanning from ptr upward, wrapping.
module rr_select #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          found_o,
  output logic [PW-1:0] idx_o
);

  logic [PW-1:0] j;

  // Scan from the far end so the candidate closest to ptr overwrites the rest.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    j       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = PW'((int'(ptr_i) + k) % N);
      if (req_i[j]) begin
        found_o = 1'b1;
        idx_o   = j;
      end
    end
  end

endmodule

// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin arbiter with burst locking feeding one registered
// valid/ready output slice.
module wrr_burst_arbiter
  import arbiter_pkg::*;
#(
  parameter int REQ_WIDTH = 4,
  parameter int DW        = 8,
  parameter int WW        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REQ_WIDTH-1:0]    valid_in,
  input  logic [REQ_WIDTH*DW-1:0] data_in,
  input  logic [REQ_WIDTH*WW-1:0] weight_in,
  output logic [REQ_WIDTH-1:0]    ready_out,
  output logic                    valid_out,
  output logic [DW-1:0]           data_out,
  input  logic                    ready_in
);

  localparam int PW = (REQ_WIDTH > 1) ? $clog2(REQ_WIDTH) : 1;

  state_e        state_q, state_d;
  logic [PW-1:0] gnt_q, gnt_d, ptr_q, ptr_d;
  logic [WW-1:0] cnt_q, cnt_d;
  logic          vout_q, vout_d;
  logic [DW-1:0] dout_q, dout_d;

  logic          found, acc, sel_valid;
  logic [PW-1:0] idx;
  logic [DW-1:0] sel_data;
  logic [WW-1:0] new_w;

  rr_select #(.N(REQ_WIDTH), .PW(PW)) u_sel (
    .req_i   (valid_in),
    .ptr_i   (ptr_q),
    .found_o (found),
    .idx_o   (idx)
  );

  assign acc       = !vout_q || ready_in;
  assign sel_valid = valid_in[gnt_q];
  assign sel_data  = data_in[int'(gnt_q)*DW +: DW];
  assign new_w     = WW'(eff_weight(WMAX'(weight_in[int'(idx)*WW +: WW])));
  assign valid_out = vout_q;
  assign data_out  = dout_q;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    vout_d    = vout_q;
    dout_d    = dout_q;
    ready_out = '0;
    if (ready_in) vout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = idx;
          cnt_d   = new_w;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // ready_out only sees registered state and ready_in, never valid_in.
        ready_out[gnt_q] = acc;
        if (sel_valid && acc) begin
          vout_d = 1'b1;
          dout_d = sel_data;
          cnt_d  = cnt_q - 1'b1;
        end
        if ((sel_valid && acc && cnt_q == WW'(1)) || (!sel_valid && acc)) begin
          ptr_d   = (gnt_q == PW'(REQ_WIDTH - 1)) ? '0 : gnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      vout_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      vout_q  <= vout_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Directed bench: expected beats (data and cycle of consumption) are queued
// as stimulus is applied and retired by a monitor on each consumed beat.
module tb_wrr_burst_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  valid_in;
  logic [31:0] data_in;
  logic [15:0] weight_in;
  logic [3:0]  ready_out;
  logic        valid_out;
  logic [7:0]  data_out;
  logic        ready_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;
  exp_t sb[$];

  wrr_burst_arbiter #(.REQ_WIDTH(4), .DW(8), .WW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .weight_in (weight_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .data_out  (data_out),
    .ready_in  (ready_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input int c);
    exp_t e;
    e.d = d;
    e.c = c;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    valid_in = '0;
    ready_in = 1'b1;
    step();
    step();
    chk("rst_valid_out", 32'(valid_out), 32'h0);
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_ready_out", 32'(ready_out), 32'h0);
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      step();
    end
    chk(tag, 32'(sb.size()), 32'h0);
    sb.delete();
  endtask

  // Monitor: a beat is consumed when valid_out and ready_in are both high.
  always @(negedge clk) begin
    if (!rst && valid_out && ready_in) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_beat: observed %0h expected none", data_out);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("beat_data", 32'(data_out), 32'(e.d));
        chk("beat_cycle", 32'(cyc - c0), 32'(e.c - c0));
      end
    end
  end

  initial begin
    rst       = 1'b1;
    valid_in  = '0;
    data_in   = 32'h87654321;
    weight_in = 16'h1111;
    ready_in  = 1'b1;
    c0        = 0;
    #1;
    chk("init_valid_out", 32'(valid_out), 32'h0);
    chk("init_data_out", 32'(data_out), 32'h0);
    chk("init_ready_out", 32'(ready_out), 32'h0);

    // Equal weights: one beat per grant, one bubble between grants.
    do_reset();
    data_in = 32'h87654321; weight_in = 16'h1111; valid_in = 4'b1111;
    c0 = cyc;
    #1 chk("idle_ready_out", 32'(ready_out), 32'h0);
    push(8'h21, c0 + 2); push(8'h43, c0 + 4); push(8'h65, c0 + 6);
    push(8'h87, c0 + 8); push(8'h21, c0 + 10);
    step();
    chk("grant_ready_out", 32'(ready_out), 32'h1);
    drain("eq_drain");
    valid_in = '0;
    step(); step(); step();
    chk("eq_quiet", 32'(valid_out), 32'h0);

    // Weighted: req0 weight 3 bursts back-to-back.
    do_reset();
    weight_in = 16'h1113; valid_in = 4'b1111;
    c0 = cyc;
    push(8'h21, c0 + 2); push(8'h21, c0 + 3); push(8'h21, c0 + 4);
    push(8'h43, c0 + 6); push(8'h65, c0 + 8); push(8'h87, c0 + 10);
    drain("wt_drain");
    valid_in = '0;

    // Downstream stall mid-burst; each beat carries distinct data.
    do_reset();
    weight_in = 16'h0003; valid_in = 4'b0001; data_in = 32'h000000A1;
    c0 = cyc;
    push(8'hA1, c0 + 2); push(8'hA2, c0 + 4); push(8'hA3, c0 + 5);
    step(); data_in = 32'h000000A1;
    step(); data_in = 32'h000000A2;
    step(); data_in = 32'h000000A3; ready_in = 1'b0;
    #1;
    chk("stall_valid_out", 32'(valid_out), 32'h1);
    chk("stall_data_out", 32'(data_out), 32'hA2);
    chk("stall_ready_out", 32'(ready_out), 32'h0);
    step(); ready_in = 1'b1;
    #1;
    chk("resume_data_out", 32'(data_out), 32'hA2);
    chk("resume_ready_out", 32'(ready_out), 32'h1);
    drain("stall_drain");
    valid_in = '0;

    // Zero weight with only req3, then req0 and req3 alternate.
    do_reset();
    data_in = 32'h87654321; weight_in = 16'h0000; valid_in = 4'b1000;
    c0 = cyc;
    push(8'h87, c0 + 2); push(8'h87, c0 + 4); push(8'h87, c0 + 6);
    for (int i = 0; i < 6; i++) step();
    valid_in = 4'b1001;
    push(8'h21, c0 + 8); push(8'h87, c0 + 10); push(8'h21, c0 + 12); push(8'h87, c0 + 14);
    drain("wrap_drain");
    valid_in = '0;

    // Early end: req1 (weight 4) drops valid after two beats, req2 follows.
    do_reset();
    weight_in = 16'h0140; valid_in = 4'b0110;
    c0 = cyc;
    push(8'h43, c0 + 2); push(8'h43, c0 + 3); push(8'h65, c0 + 6);
    step(); step(); step();
    valid_in = 4'b0100;
    chk("early_ready_out", 32'(ready_out), 32'h2);
    drain("early_drain");
    valid_in = '0;

    // Asynchronous reset in the middle of a burst.
    do_reset();
    weight_in = 16'h1113; valid_in = 4'b1111;
    c0 = cyc;
    step(); step();
    chk("pre_rst_valid_out", 32'(valid_out), 32'h1);
    chk("pre_rst_data_out", 32'(data_out), 32'h21);
    chk("pre_rst_ready_out", 32'(ready_out), 32'h1);
    rst = 1'b1;
    #1;
    chk("async_valid_out", 32'(valid_out), 32'h0);
    chk("async_data_out", 32'(data_out), 32'h0);
    chk("async_ready_out", 32'(ready_out), 32'h0);
    do_reset();
    valid_in = 4'b1111;
    c0 = cyc;
    push(8'h21, c0 + 2); push(8'h21, c0 + 3); push(8'h21, c0 + 4); push(8'h43, c0 + 6);
    drain("post_rst_drain");
    valid_in = '0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
